// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshake and registered result/zero/illegal.
// Define SEQ_ALU_MUL_EN to compile in the XLEN-cycle shift-add multiplier (ALUctr 1001).
module seq_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      ALUctr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef SEQ_ALU_MUL_EN
        BUSY = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            load_alu;

    logic            is_sub;
    logic [XLEN-1:0] b_op;
    logic [XLEN:0]   sum;
    logic            ovf;
    logic            slt;
    logic            sltu;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            alu_illegal;

    assign accept = in_valid && in_ready;

    // One adder serves ADD, SUB and both compares; subtraction is A + ~B + 1.
    assign is_sub = (ALUctr == 4'b1000) || (ALUctr == 4'b0010) || (ALUctr == 4'b0011);
    assign b_op   = is_sub ? ~B : B;
    assign sum    = {1'b0, A} + {1'b0, b_op} + {{XLEN{1'b0}}, is_sub};
    assign ovf    = (A[XLEN-1] == b_op[XLEN-1]) && (sum[XLEN-1] != A[XLEN-1]);
    assign slt    = sum[XLEN-1] ^ ovf;
    assign sltu   = ~sum[XLEN];
    assign shamt  = B[SHW-1:0];

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (ALUctr)
            4'b0000, 4'b1000: alu_res = sum[XLEN-1:0];
            4'b0010:          alu_res = {{(XLEN-1){1'b0}}, slt};
            4'b0011:          alu_res = {{(XLEN-1){1'b0}}, sltu};
            4'b0110:          alu_res = A | B;
            4'b0111:          alu_res = A & B;
            4'b0100:          alu_res = A ^ B;
            4'b1111:          alu_res = B;
            4'b0001:          alu_res = A << shamt;
            4'b0101:          alu_res = A >> shamt;
            4'b1101:          alu_res = $signed(A) >>> shamt;
            default:          alu_illegal = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    logic            is_mul;
    logic            mul_last;
    logic [XLEN-1:0] mul_acc;
    logic [XLEN-1:0] mul_a;
    logic [XLEN-1:0] mul_b;
    logic [XLEN-1:0] mul_next;
    logic [SHW-1:0]  mul_cnt;

    assign is_mul   = (ALUctr == 4'b1001);
    assign load_alu = accept && !is_mul;
    assign mul_next = mul_acc + (mul_b[0] ? mul_a : '0);
    assign mul_last = (state == BUSY) && (mul_cnt == SHW'(XLEN - 1));

    // Multiplicand shifts left and multiplier right, one bit of B consumed per BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_acc <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_cnt <= '0;
        end else if (accept && is_mul) begin
            mul_acc <= '0;
            mul_a   <= A;
            mul_b   <= B;
            mul_cnt <= '0;
        end else if (state == BUSY) begin
            mul_acc <= mul_next;
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            mul_cnt <= mul_cnt + SHW'(1);
        end
    end
`else
    assign load_alu = accept;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
`ifdef SEQ_ALU_MUL_EN
                if (accept) state_next = is_mul ? BUSY : DONE;
`else
                if (accept) state_next = DONE;
`endif
            end
`ifdef SEQ_ALU_MUL_EN
            BUSY: begin
                if (mul_last) state_next = DONE;
            end
`endif
            DONE: begin
`ifdef SEQ_ALU_MUL_EN
                if (accept) state_next = is_mul ? BUSY : DONE;
`else
                if (accept) state_next = DONE;
`endif
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == DONE);
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    end

    // Result stays put until the next accepted op (or multiplier completion) overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (load_alu) begin
            result  <= alu_res;
            zero    <= (alu_res == '0);
            illegal <= alu_illegal;
`ifdef SEQ_ALU_MUL_EN
        end else if (mul_last) begin
            result  <= mul_next;
            zero    <= (mul_next == '0);
            illegal <= 1'b0;
`endif
        end
    end

endmodule
